pc_sequencer: RTL and testbench

- Owns the program counter and drives instruction fetch.
- Sits at the receiving end of the main decoder's control outputs. It takes the Branch/jal/jalr flags, delayed through ID/EX, together with the EX-stage compare result and operands, and resolves the next PC.
- Issues fetch requests to instruction memory over a request/ready handshake, allowing up to MAX_OUTST requests in flight.
- Generates the pipeline flush and discards stale fetch responses after a redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 30 +++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: control-flow opcodes, PC sequencer states and default widths.
package riscv_pkg;

  localparam int PC_W_DEF = 32;

  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } pc_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational branch/jump resolution in EX: taken decision, redirect target and alignment flag.
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_cond,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_imm,
  input  logic [PC_W-1:0] ex_rs1,
  output logic            taken,
  output logic [PC_W-1:0] target,
  output logic            misalign
);

  logic [PC_W-1:0] jalr_sum;

  always_comb begin
    jalr_sum = ex_rs1 + ex_imm;
    taken    = ex_valid & (ex_jal | ex_jalr | (ex_branch & ex_cond));
    // jalr clears bit 0 of the sum; any remaining bit-1 offset is reported, not fixed.
    target   = ex_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : (ex_pc + ex_imm);
    misalign = taken & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: issues in-order fetches with bounded outstanding requests,
// redirects on taken control flow and squashes responses that belong to the old stream.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_cond,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_imm,
  input  logic [PC_W-1:0] ex_rs1,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  output logic            if_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush,
  output logic            misalign_err,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] MAX_C = 2'(MAX_OUTST);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      kill_q, kill_d;
  logic            taken, misalign, accept, resp;
  logic [PC_W-1:0] target;

  next_pc_calc #(.PC_W(PC_W)) u_calc (
    .ex_valid  (ex_valid),
    .ex_branch (ex_branch),
    .ex_jal    (ex_jal),
    .ex_jalr   (ex_jalr),
    .ex_cond   (ex_cond),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .taken     (taken),
    .target    (target),
    .misalign  (misalign)
  );

  // Fetch handshake: a request transfers on a cycle with imem_req & imem_ready; while
  // imem_req is high and not yet accepted, imem_addr (= pc_q) holds, since pc_q only
  // moves on acceptance or redirect. Responses return in order, one per accepted request.
  always_comb begin
    imem_req     = (state_q == RUN) & ~stall & ~taken;
    accept       = imem_req & imem_ready;
    resp         = imem_rvalid & (outst_q != 2'd0);
    if_valid     = resp & (kill_q == 2'd0);
    flush        = taken & reset;
    misalign_err = misalign & reset;

    outst_d = outst_q + {1'b0, accept} - {1'b0, resp};

    // On redirect, everything still in flight belongs to the abandoned stream.
    kill_d = kill_q;
    if (taken)                          kill_d = outst_q - {1'b0, resp};
    else if (resp && kill_q != 2'd0)    kill_d = kill_q - 2'd1;

    pc_d = pc_q;
    if (taken)       pc_d = target;
    else if (accept) pc_d = pc_q + PC_W'(4);

    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (outst_d == MAX_C) state_d = FULL;
      FULL:    if (outst_d < MAX_C)  state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= 2'd0;
      kill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_W'(4);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic against a fetch-stream model.
module tb_pc_sequencer;

  localparam int          PC_W      = 32;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0, ex_cond = 1'b0;
  logic [31:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0, if_valid, flush, misalign_err;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [1:0]  dbg_state;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_cond(ex_cond), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .if_valid(if_valid), .pc(pc), .pc_plus4(pc_plus4),
    .flush(flush), .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [0:0]  exp_q[$];      // one entry per fetch in flight: 1 = response is wanted
  logic [31:0] pc_m = RESET_PC;
  bit          boot_m = 1'b1;
  int          mem_pending = 0;
  int          rdy_pct = 100, rv_pct = 100, spur_pct = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic v, input logic br, input logic j, input logic jr,
                        input logic c, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] r);
    ex_valid = v; ex_branch = br; ex_jal = j; ex_jalr = jr; ex_cond = c;
    ex_pc = p; ex_imm = im; ex_rs1 = r;
  endtask

  task automatic drive_mem();
    imem_ready = ($urandom_range(99) < rdy_pct);
    if (mem_pending > 0) imem_rvalid = ($urandom_range(99) < rv_pct);
    else                 imem_rvalid = ($urandom_range(99) < spur_pct);
  endtask

  // One clock: called at a negedge with control inputs set; checks mid-cycle, updates model at posedge.
  task automatic tick();
    logic        tk, e_req, e_ifv;
    logic [31:0] tgt;
    drive_mem();
    #1;
    tk  = ex_valid && (ex_jal || ex_jalr || (ex_branch && ex_cond));
    tgt = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
    e_req = 1'b0;
    if (!reset) begin
      check("rst_req", imem_req, 0);
      check("rst_flush", flush, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_pc", pc, RESET_PC);
    end else begin
      e_req = !boot_m && (exp_q.size() < MAX_OUTST) && !stall && !tk;
      e_ifv = 1'b0;
      if (imem_rvalid && exp_q.size() > 0) e_ifv = exp_q[0];
      check("req", imem_req, e_req);
      check("pc", pc, pc_m);
      check("addr", imem_addr, pc_m);
      check("pc_plus4", pc_plus4, pc_m + 32'd4);
      check("flush", flush, tk);
      check("misalign", misalign_err, tk && (tgt[1:0] != 2'b00));
      check("if_valid", if_valid, e_ifv);
    end
    if (imem_rvalid && mem_pending > 0) mem_pending--;
    if (imem_req && imem_ready) mem_pending++;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      pc_m   = RESET_PC;
      boot_m = 1'b1;
    end else begin
      boot_m = 1'b0;
      if (imem_rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tk) begin
        pc_m = tgt;
        foreach (exp_q[i]) exp_q[i] = 1'b0;
      end else if (e_req && imem_ready) begin
        pc_m = pc_m + 32'd4;
        exp_q.push_back(1'b1);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();

    // Sequential fetch from reset with single-cycle responses.
    reset = 1'b1; rdy_pct = 100; rv_pct = 100; spur_pct = 0;
    for (int i = 0; i < 10 && pc_m != 32'd8; i++) tick();
    check("reach_pc8", pc, 32'd8);

    // Memory back-pressure holds the address.
    rdy_pct = 0;
    repeat (3) tick();
    check("hold_pc8", imem_addr, 32'd8);
    rdy_pct = 100;
    repeat (3) tick();

    // Taken beq with two fetches in flight.
    rv_pct = 0;
    for (int i = 0; i < 10 && exp_q.size() < MAX_OUTST; i++) tick();
    check("full_state", dbg_state, 32'd2);
    set_ex(1, 1, 0, 0, 1, 32'd16, 32'hFFFF_FFF8, 32'd0);
    tick();
    set_ex(0, 0, 0, 0, 0, '0, '0, '0);
    rv_pct = 100;
    check("beq_pc", pc, 32'd8);
    repeat (5) tick();

    // jalr under stall: redirect wins, odd offset reported.
    stall = 1'b1;
    set_ex(1, 1, 0, 1, 0, 32'd40, 32'd2, 32'h101);
    tick();
    set_ex(0, 0, 0, 0, 0, '0, '0, '0);
    check("jalr_pc", pc, 32'h102);
    tick();
    stall = 1'b0;

    // Non-taken cases: beq with cond=0, jal without ex_valid.
    set_ex(1, 1, 0, 0, 0, 32'd64, 32'd100, 32'd0);
    tick();
    set_ex(0, 1, 1, 0, 1, 32'd64, 32'd100, 32'd0);
    tick();
    set_ex(0, 0, 0, 0, 0, '0, '0, '0);
    repeat (3) tick();

    // Reset pulse with two fetches in flight; late responses must be dropped.
    rv_pct = 0;
    for (int i = 0; i < 10 && exp_q.size() < MAX_OUTST; i++) tick();
    check("full_before_rst", dbg_state, 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1; rdy_pct = 0; rv_pct = 100;
    for (int i = 0; i < 10 && mem_pending > 0; i++) tick();
    check("late_drained", mem_pending, 0);
    rdy_pct = 100;
    repeat (4) tick();

    // Random traffic.
    rdy_pct = 70; rv_pct = 60; spur_pct = 10;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(199) != 0);
      stall = ($urandom_range(99) < 20);
      kind  = $urandom_range(7);
      set_ex($urandom_range(99) < 15, kind >= 4, kind == 4, kind == 5, $urandom_range(1),
             $urandom & 32'hFFFF_FFFC, 32'($urandom_range(63)) - 32'd32, $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
